uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Oversampled UART receiver with run-time framing options: parity none/even/odd, 1 or 2 stop bits.
//  Adds an input synchroniser, false-start rejection, and parity/framing error flags.
//  Sits between the pad-side rx line and the byte consumer (FIFO/interface FSM).
//  Shares the baud-rate generator s_tick with the transmitter.
// PARAMETERS
//  NB_DATA   8   data bits per frame, 5..9
//  S_TICK    16  s_tick pulses per bit period, even, >=8
// PORTS
//  clk             in   1        clock
//  reset           in   1        synchronous, active-high
//  rx              in   1        asynchronous serial line, idle high
//  s_tick          in   1        oversample strobe, 1-clk pulse
//  cfg_parity_en   in   1        1: parity bit follows data
//  cfg_parity_odd  in   1        1: odd parity, 0: even (ignored if !cfg_parity_en)
//  cfg_two_stop    in   1        1: two stop bits
//  rx_done_tick    out  1        1-clk pulse, frame complete
//  data_out        out  NB_DATA  received word, LSB first on line, held until next done
//  parity_err      out  1        valid with rx_done_tick, held until next done
//  frame_err       out  1        valid with rx_done_tick, held until next done
// BEHAVIOUR
//  - Reset: FSM=IDLE; all counters 0; rx_done_tick=0, data_out=0, parity_err=0, frame_err=0.
//  - Reset mid-frame aborts the frame: no done pulse, flags cleared.
//  - rx passes a 2-FF synchroniser (sync output resets to 1); all FSM decisions use rx_s.
//  - cfg_* inputs are sampled into shadow regs on the IDLE->START transition; changes mid-frame are ignored.
//  - Tick counter: 0..S_TICK-1; it advances only on s_tick.
//  - IDLE: rx_s==0 -> START, tick counter=0.
//  - START: on the s_tick where count==S_TICK/2-1 (mid start bit), check the sample.
//      - Sample 1 -> IDLE (glitch rejected, no flags).
//      - Sample 0 -> DATA, count=0, bit index=0.
//  - DATA: on the s_tick where count==S_TICK-1, sample the bit.
//      - Shift right, new bit at MSB; toggle running parity.
//      - After NB_DATA bits -> PARITY if enabled, else STOP.
//  - PARITY: at count==S_TICK-1, sample. parity_err_next = (XOR data ^ sample) != cfg_parity_odd.
//  - STOP: at count==S_TICK-1, sample; a sample of 0 sets frame_err_next.
//      - With two stop bits, a second STOP bit period follows; either 0 sets frame_err.
//      - After the last stop sample: rx_done_tick=1 that clk; data_out, parity_err, frame_err updated the same edge; -> IDLE.
//  - Done timing: done fires at mid last stop bit, so a back-to-back start edge is detected.
//  - Latency, rx pin to IDLE exit: 2 clk (synchroniser).
//  - Break (all zeros incl. stop): done with frame_err=1, data_out=0; FSM then waits in IDLE until rx_s returns 1 before arming again.
//  - Counters wrap only via explicit reset to 0; s_tick coincident with state change is consumed by the transition.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined:
//    - Each data/parity/stop bit is the 2-of-3 majority of rx_s at counts S_TICK-3, S_TICK-2, S_TICK-1.
//    - The start-bit check uses the majority at S_TICK/2-3..S_TICK/2-1.
//  UART_RX_MAJORITY_EN undefined: single sample at the count listed in BEHAVIOUR; no sample registers.
// STRUCTURE
//  uart_pkg: FSM state localparams (IDLE, START, DATA, PARITY, STOP); PARITY_EVEN/PARITY_ODD constants.
//  Sub-module uart_rx_sync: 2-FF synchroniser, reset value 1, shared with later blocks.
//  Datapath (shift reg, parity, counters) and FSM stay in uart_rx_cfg.
// TESTING (NB_DATA=8, S_TICK=16, s_tick every 4 clk)
//  1. 8N1 frame 0xA5 -> one done pulse, data_out=0xA5, parity_err=0, frame_err=0.
//  2. 8E1 frame 0x03, parity bit 1 -> done, data_out=0x03, parity_err=1. Same with cfg_parity_odd=1 -> parity_err=0.
//  3. 8N2 frame 0x5A, second stop bit driven 0 -> done, data_out=0x5A, frame_err=1.
//  4. rx low pulse of 3 ticks then high -> no done, FSM back to IDLE.
//     With UART_RX_MAJORITY_EN, a 1-tick glitch mid data bit does not flip the bit.
//  5. reset asserted during DATA bit 4, then clean frame 0x7E -> no done for the aborted frame; next done data_out=0x7E.
//  6. Break: rx held low 12 bit times -> one done, data_out=0x00, frame_err=1; no second done until rx high then a new start bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity sense constants
// and the 2-of-3 vote used when oversampled bit voting is built in.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pad; resets to the idle
// (high) line level so a reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s
);

    logic rx_meta;

    // Double-register the pad input into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with run-time parity (none/even/odd) and
// 1/2 stop bits, false-start rejection and parity/framing error flags.
// Build option: define UART_RX_MAJORITY_EN to take each bit as the 2-of-3
// vote of the last three oversamples before the sample point.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int S_TICK  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx,
    input  logic               s_tick,
    input  logic               cfg_parity_en,
    input  logic               cfg_parity_odd,
    input  logic               cfg_two_stop,
    output logic               rx_done_tick,
    output logic [NB_DATA-1:0] data_out,
    output logic               parity_err,
    output logic               frame_err
);

    localparam int CW = $clog2(S_TICK);
    localparam int IW = $clog2(NB_DATA + 1);
    localparam logic [CW-1:0] START_PT = CW'(S_TICK / 2 - 1);
    localparam logic [CW-1:0] BIT_PT   = CW'(S_TICK - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NB_DATA - 1);

    logic               rx_s;
    state_t             state;
    logic [CW-1:0]      cnt;
    logic [IW-1:0]      idx;
    logic [NB_DATA-1:0] shreg;
    logic               par_acc;
    logic               perr_acc;
    logic               ferr_acc;
    logic               stop_idx;
    logic               pen_q;
    logic               odd_q;
    logic               two_q;
    logic               wait_high;
    logic [CW-1:0]      sample_pt;
    logic               at_sample;
    logic               bit_now;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rx_s  (rx_s)
    );

    assign sample_pt = (state == START) ? START_PT : BIT_PT;
    assign at_sample = s_tick && (cnt == sample_pt);

`ifdef UART_RX_MAJORITY_EN
    logic samp_a;
    logic samp_b;

    // Capture the two oversamples preceding the sample point for the vote.
    always_ff @(posedge clk) begin
        if (reset) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else if (s_tick) begin
            if (cnt == sample_pt - CW'(2)) samp_a <= rx_s;
            if (cnt == sample_pt - CW'(1)) samp_b <= rx_s;
        end
    end

    assign bit_now = maj3(samp_a, samp_b, rx_s);
`else
    assign bit_now = rx_s;
`endif

    // Receiver FSM with datapath: framing, shifting, parity and error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            par_acc      <= 1'b0;
            perr_acc     <= 1'b0;
            ferr_acc     <= 1'b0;
            stop_idx     <= 1'b0;
            pen_q        <= 1'b0;
            odd_q        <= 1'b0;
            two_q        <= 1'b0;
            wait_high    <= 1'b0;
            rx_done_tick <= 1'b0;
            data_out     <= '0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    // After a frame ending with the line low (break), hold
                    // off until the line has gone back to idle.
                    if (wait_high) begin
                        if (rx_s) wait_high <= 1'b0;
                    end else if (!rx_s) begin
                        state    <= START;
                        cnt      <= '0;
                        idx      <= '0;
                        stop_idx <= 1'b0;
                        par_acc  <= 1'b0;
                        perr_acc <= 1'b0;
                        ferr_acc <= 1'b0;
                        pen_q    <= cfg_parity_en;
                        odd_q    <= cfg_parity_odd;
                        two_q    <= cfg_two_stop;
                    end
                end
                START: begin
                    if (at_sample) begin
                        cnt <= '0;
                        if (bit_now) state <= IDLE;
                        else begin
                            state <= DATA;
                            idx   <= '0;
                        end
                    end else if (s_tick) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (at_sample) begin
                        cnt     <= '0;
                        shreg   <= {bit_now, shreg[NB_DATA-1:1]};
                        par_acc <= par_acc ^ bit_now;
                        if (idx == LAST_IDX) state <= pen_q ? PARITY : STOP;
                        else                 idx   <= idx + IW'(1);
                    end else if (s_tick) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PARITY: begin
                    if (at_sample) begin
                        cnt      <= '0;
                        perr_acc <= (((par_acc ^ bit_now) != 1'b0) ? PARITY_ODD : PARITY_EVEN) != odd_q;
                        state    <= STOP;
                    end else if (s_tick) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (at_sample) begin
                        cnt <= '0;
                        if (two_q && !stop_idx) begin
                            stop_idx <= 1'b1;
                            ferr_acc <= ferr_acc | !bit_now;
                        end else begin
                            // Mid last stop bit: publish so a back-to-back
                            // start edge is still caught.
                            rx_done_tick <= 1'b1;
                            data_out     <= shreg;
                            parity_err   <= pen_q & perr_acc;
                            frame_err    <= ferr_acc | !bit_now;
                            wait_high    <= !bit_now;
                            state        <= IDLE;
                        end
                    end else if (s_tick) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: directed frame table, randomized frames against
// a frame-level reference model, and hand-written corner sequences.
module tb_uart_rx_cfg;

    localparam int NB      = 8;
    localparam int ST      = 16;
    localparam int TPB     = 4;
    localparam int BIT_CLK = ST * TPB;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic          s_tick;
    logic          cfg_parity_en;
    logic          cfg_parity_odd;
    logic          cfg_two_stop;
    logic          rx_done_tick;
    logic [NB-1:0] data_out;
    logic          parity_err;
    logic          frame_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        logic       pen, podd, two, pbit, st1, st2;
        logic [7:0] e_data;
        logic       e_perr, e_ferr;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       perr, ferr;
    } rec_t;

    rec_t mq[$];
    vec_t tbl[8];

    uart_rx_cfg #(.NB_DATA(NB), .S_TICK(ST)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx             (rx),
        .s_tick         (s_tick),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_two_stop   (cfg_two_stop),
        .rx_done_tick   (rx_done_tick),
        .data_out       (data_out),
        .parity_err     (parity_err),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (TPB - 1) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) mq.push_back('{data_out, parity_err, frame_err});
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic po, input logic tw,
                              input logic pb, input logic s1, input logic s2, input logic scramble);
        cfg_parity_en  = pe;
        cfg_parity_odd = po;
        cfg_two_stop   = tw;
        rx = 1'b0;
        wait_clks(BIT_CLK);
        if (scramble) begin
            cfg_parity_en  = 1'($urandom);
            cfg_parity_odd = 1'($urandom);
            cfg_two_stop   = 1'($urandom);
        end
        for (int i = 0; i < NB; i++) begin
            rx = d[i];
            wait_clks(BIT_CLK);
        end
        if (pe) begin
            rx = pb;
            wait_clks(BIT_CLK);
        end
        rx = s1;
        wait_clks(BIT_CLK);
        if (tw) begin
            rx = s2;
            wait_clks(BIT_CLK);
        end
        rx = 1'b1;
        wait_clks(2 * BIT_CLK);
    endtask

    task automatic check_frame(input string nm, input logic [7:0] ed, input logic ep, input logic ef);
        rec_t r;
        chk({nm, "_ndone"}, 32'(mq.size()), 32'd1);
        if (mq.size() > 0) begin
            r = mq.pop_front();
            chk({nm, "_data"}, 32'(r.data), 32'(ed));
            chk({nm, "_perr"}, 32'(r.perr), 32'(ep));
            chk({nm, "_ferr"}, 32'(r.ferr), 32'(ef));
        end
        mq.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic       pe, po, tw, pb, s1, s2, ep, ef;

        tbl[0] = '{8'hA5, 0, 0, 0, 0, 1, 1, 8'hA5, 0, 0};
        tbl[1] = '{8'h03, 1, 0, 0, 1, 1, 1, 8'h03, 1, 0};
        tbl[2] = '{8'h03, 1, 1, 0, 1, 1, 1, 8'h03, 0, 0};
        tbl[3] = '{8'h5A, 0, 0, 1, 0, 1, 0, 8'h5A, 0, 1};
        tbl[4] = '{8'h5A, 0, 0, 1, 0, 0, 1, 8'h5A, 0, 1};
        tbl[5] = '{8'hFF, 1, 1, 0, 0, 1, 1, 8'hFF, 1, 0};
        tbl[6] = '{8'h00, 1, 0, 0, 0, 1, 1, 8'h00, 0, 0};
        tbl[7] = '{8'h81, 1, 0, 1, 0, 1, 1, 8'h81, 0, 0};

        reset = 1'b1;
        rx = 1'b1;
        cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b0;
        cfg_two_stop = 1'b0;
        wait_clks(4);
        chk("rst_done", 32'(rx_done_tick), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        reset = 1'b0;
        wait_clks(BIT_CLK);
        chk("idle_ndone", 32'(mq.size()), 32'd0);

        // Directed frame table
        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].data, tbl[i].pen, tbl[i].podd, tbl[i].two,
                       tbl[i].pbit, tbl[i].st1, tbl[i].st2, 1'b0);
            check_frame($sformatf("tbl%0d", i), tbl[i].e_data, tbl[i].e_perr, tbl[i].e_ferr);
        end

        // Random frames, cfg scrambled after the start bit
        for (int i = 0; i < 30; i++) begin
            d  = 8'($urandom);
            pe = 1'($urandom);
            po = 1'($urandom);
            tw = 1'($urandom);
            pb = 1'($urandom);
            s1 = ($urandom_range(3, 0) != 0);
            s2 = ($urandom_range(3, 0) != 0);
            ep = pe && ((($countones(d) + int'(pb)) % 2) != int'(po));
            ef = !s1 || (tw && !s2);
            send_frame(d, pe, po, tw, pb, s1, s2, 1'b1);
            check_frame($sformatf("rnd%0d", i), d, ep, ef);
        end

        // Short low pulse: false start must be rejected
        rx = 1'b0;
        wait_clks(3 * TPB);
        rx = 1'b1;
        wait_clks(3 * BIT_CLK);
        chk("glitch_ndone", 32'(mq.size()), 32'd0);
        mq.delete();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_frame("post_glitch", 8'h3C, 1'b0, 1'b0);

        // Reset in the middle of data bit 4 aborts the frame
        cfg_parity_en = 1'b0;
        cfg_two_stop = 1'b0;
        rx = 1'b0;
        wait_clks(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            wait_clks(BIT_CLK);
        end
        rx = 1'b0;
        wait_clks(BIT_CLK / 2);
        reset = 1'b1;
        rx = 1'b1;
        wait_clks(4);
        reset = 1'b0;
        wait_clks(12 * BIT_CLK);
        chk("abort_ndone", 32'(mq.size()), 32'd0);
        chk("abort_data", 32'(data_out), 32'd0);
        chk("abort_ferr", 32'(frame_err), 32'd0);
        mq.delete();
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_frame("post_abort", 8'h7E, 1'b0, 1'b0);

        // Break: line low for 12 bit times, one done only
        cfg_parity_en = 1'b0;
        cfg_two_stop = 1'b0;
        rx = 1'b0;
        wait_clks(12 * BIT_CLK);
        check_frame("break", 8'h00, 1'b0, 1'b1);
        rx = 1'b1;
        wait_clks(12 * BIT_CLK);
        chk("break_rearm_ndone", 32'(mq.size()), 32'd0);
        mq.delete();
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_frame("post_break", 8'hC3, 1'b0, 1'b0);

`ifdef UART_RX_MAJORITY_EN
        // One-tick glitch in the middle of data bit 3 must be voted out
        cfg_parity_en = 1'b0;
        cfg_two_stop = 1'b0;
        rx = 1'b0;
        wait_clks(BIT_CLK);
        for (int i = 0; i < NB; i++) begin
            if (i == 3) begin
                wait_clks(BIT_CLK / 2 - 2);
                rx = 1'b1;
                wait_clks(TPB);
                rx = 1'b0;
                wait_clks(BIT_CLK / 2 - 2);
            end else begin
                wait_clks(BIT_CLK);
            end
        end
        rx = 1'b1;
        wait_clks(3 * BIT_CLK);
        check_frame("maj_glitch", 8'h00, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
